// File: rtl/alu32_if.sv
// Operand/opcode bus into the ALU and registered result/flag bus out of it.
interface alu32_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [3:0]  op;
  logic [31:0] result;
  logic        C;
  logic        N;
  logic        V;
  logic        Z;

  // Issuer side: drives operands, observes result and flags.
  modport master (
    output A, B, Cin, op,
    input  result, C, N, V, Z
  );

  // ALU side: consumes operands, produces result and flags.
  modport slave (
    input  A, B, Cin, op,
    output result, C, N, V, Z
  );
endinterface

// File: rtl/alu32.sv
// 32-bit single-cycle registered ALU: 16 arithmetic/logic/shift operations with
// ARM-style C/N/V/Z condition codes, one cycle of latency, no handshake.
module alu32 (
  input  logic    clk,
  input  logic    rst_n,
  alu32_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_ADC  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_SBC  = 4'b0011,
    OP_RSB  = 4'b0100,
    OP_RSC  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_ORR  = 4'b0111,
    OP_EOR  = 4'b1000,
    OP_BIC  = 4'b1001,
    OP_MOV  = 4'b1010,
    OP_MVN  = 4'b1011,
    OP_PASA = 4'b1100,
    OP_NOTA = 4'b1101,
    OP_LSL  = 4'b1110,
    OP_LSR  = 4'b1111
  } op_e;

  op_e             op_c;
  logic [DW-1:0]   add_x_c;
  logic [DW-1:0]   add_y_c;
  logic            add_cin_c;
  logic [DW:0]     sum_c;
  logic            add_v_c;
  logic [SW-1:0]   shamt_c;
  logic [DW:0]     shl_ext_c;
  logic [DW:0]     shr_ext_c;

  logic [DW-1:0]   result_d, result_q;
  logic            c_d, c_q;
  logic            v_d, v_q;
  logic            n_d, n_q;
  logic            z_d, z_q;

  assign op_c    = op_e'(bus.op);
  assign shamt_c = bus.B[SW-1:0];

  // Adder operand steering: subtract forms invert one operand, carry-in picks +1 or Cin.
  always_comb begin
    add_x_c   = bus.A;
    add_y_c   = bus.B;
    add_cin_c = 1'b0;
    case (op_c)
      OP_ADD: begin
        add_x_c   = bus.A;
        add_y_c   = bus.B;
        add_cin_c = 1'b0;
      end
      OP_ADC: begin
        add_x_c   = bus.A;
        add_y_c   = bus.B;
        add_cin_c = bus.Cin;
      end
      OP_SUB: begin
        add_x_c   = bus.A;
        add_y_c   = ~bus.B;
        add_cin_c = 1'b1;
      end
      OP_SBC: begin
        add_x_c   = bus.A;
        add_y_c   = ~bus.B;
        add_cin_c = bus.Cin;
      end
      OP_RSB: begin
        add_x_c   = bus.B;
        add_y_c   = ~bus.A;
        add_cin_c = 1'b1;
      end
      OP_RSC: begin
        add_x_c   = bus.B;
        add_y_c   = ~bus.A;
        add_cin_c = bus.Cin;
      end
      default: begin
        add_x_c   = bus.A;
        add_y_c   = bus.B;
        add_cin_c = 1'b0;
      end
    endcase
  end

  // 33-bit sum; bit 32 is carry out (NOT borrow for subtract forms).
  assign sum_c   = {1'b0, add_x_c} + {1'b0, add_y_c} + (DW+1)'(add_cin_c);
  // Signed overflow: like-signed adder inputs producing an opposite-signed sum.
  assign add_v_c = (add_x_c[DW-1] == add_y_c[DW-1]) && (sum_c[DW-1] != add_x_c[DW-1]);

  // Shifters widened by one bit so the last bit shifted out lands in the extra bit;
  // a zero shift leaves that bit 0, giving C=0 for free.
  assign shl_ext_c = {1'b0, bus.A} << shamt_c;
  assign shr_ext_c = {bus.A, 1'b0} >> shamt_c;

  // Result and flag selection for the next register load.
  always_comb begin
    result_d = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    case (op_c)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB, OP_RSC: begin
        result_d = sum_c[DW-1:0];
        c_d      = sum_c[DW];
        v_d      = add_v_c;
      end
      OP_AND:  result_d = bus.A & bus.B;
      OP_ORR:  result_d = bus.A | bus.B;
      OP_EOR:  result_d = bus.A ^ bus.B;
      OP_BIC:  result_d = bus.A & ~bus.B;
      OP_MOV:  result_d = bus.B;
      OP_MVN:  result_d = ~bus.B;
      OP_PASA: result_d = bus.A;
      OP_NOTA: result_d = ~bus.A;
      OP_LSL: begin
        result_d = shl_ext_c[DW-1:0];
        c_d      = shl_ext_c[DW];
      end
      OP_LSR: begin
        result_d = shr_ext_c[DW:1];
        c_d      = shr_ext_c[0];
      end
      default: begin
        result_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
      end
    endcase
    n_d = result_d[DW-1];
    z_d = (result_d == '0);
  end

  // Output register with synchronous active-low reset taking priority over new inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign bus.result = result_q;
  assign bus.C      = c_q;
  assign bus.N      = n_q;
  assign bus.V      = v_q;
  assign bus.Z      = z_q;

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: a driver issues directed vectors and queues their
// hand-computed results; an independent monitor checks each output cycle.
module tb_alu32;

  logic clk;
  logic rst_n;
  alu32_if bus ();

  alu32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [35:0] exp_q[$];   // {result, C, N, V, Z}
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Issue one vector on the falling edge and record what must appear after the next rising edge.
  task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] op,
                       input logic [31:0] exp_res, input logic [3:0] exp_cnvz,
                       input string name);
    @(negedge clk);
    rst_n   = rst;
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
    bus.op  = op;
    exp_q.push_back({exp_res, exp_cnvz});
    name_q.push_back(name);
  endtask

  // Monitor: every output cycle with a pending expectation is compared.
  initial begin
    logic [35:0] exp;
    logic [35:0] act;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.result, bus.C, bus.N, bus.V, bus.Z};
        n_cmp++;
        if (act !== exp) begin
          n_err++;
          $display("FAIL %s: got result=%h CNVZ=%b, expected result=%h CNVZ=%b",
                   nm, act[35:4], act[3:0], exp[35:4], exp[3:0]);
        end
      end
    end
  end

  initial begin
    int waited;
    rst_n   = 1'b1;
    bus.A   = '0;
    bus.B   = '0;
    bus.Cin = 1'b0;
    bus.op  = 4'b0000;

    //     rst   A             B             Cin   op       result        CNVZ
    drive(1'b0, 32'd5,        32'd7,        1'b0, 4'b0000, 32'd0,        4'b0000, "reset");
    drive(1'b1, 32'd5,        32'd7,        1'b0, 4'b0000, 32'd12,       4'b0000, "release_add");
    drive(1'b1, 32'd0,        32'd0,        1'b0, 4'b0000, 32'd0,        4'b0001, "zero");
    drive(1'b1, 32'd93,       32'd106,      1'b1, 4'b0001, 32'd200,      4'b0000, "adc");
    drive(1'b1, 32'h7FFFFFFD, 32'd2,        1'b0, 4'b0000, 32'h7FFFFFFF, 4'b0000, "add_max");
    drive(1'b1, 32'h7FFFFFFF, 32'd2,        1'b0, 4'b0000, 32'h80000001, 4'b0110, "add_ovf");
    drive(1'b1, 32'h80000002, 32'd2,        1'b0, 4'b0010, 32'h80000000, 4'b1100, "sub_min");
    drive(1'b1, 32'h80000000, 32'd2,        1'b0, 4'b0010, 32'h7FFFFFFE, 4'b1010, "sub_ovf");
    drive(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 4'b0110, 32'hF000F000, 4'b0100, "and");
    drive(1'b1, 32'h80000001, 32'd1,        1'b0, 4'b1110, 32'h00000002, 4'b1000, "lsl_carry");
    drive(1'b1, 32'hFFFFFFFF, 32'd1,        1'b0, 4'b0000, 32'd0,        4'b1001, "add_carry");
    drive(1'b1, 32'd1,        32'd1,        1'b1, 4'b0000, 32'd2,        4'b0000, "add_ignores_cin");
    drive(1'b1, 32'd10,       32'd3,        1'b0, 4'b0011, 32'd6,        4'b1000, "sbc");
    drive(1'b1, 32'd3,        32'd10,       1'b0, 4'b0100, 32'd7,        4'b1000, "rsb");
    drive(1'b1, 32'd10,       32'd3,        1'b1, 4'b0101, 32'hFFFFFFF9, 4'b0100, "rsc");
    drive(1'b1, 32'hF0F0F0F0, 32'h0F0F0000, 1'b1, 4'b0111, 32'hFFFFF0F0, 4'b0100, "orr");
    drive(1'b1, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 4'b1000, 32'd0,        4'b0001, "eor");
    drive(1'b1, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 4'b1001, 32'hFFFF0000, 4'b0100, "bic");
    drive(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0, 4'b1010, 32'h12345678, 4'b0000, "mov");
    drive(1'b1, 32'h12345678, 32'd0,        1'b0, 4'b1011, 32'hFFFFFFFF, 4'b0100, "mvn");
    drive(1'b1, 32'h80000000, 32'd5,        1'b1, 4'b1100, 32'h80000000, 4'b0100, "pasa");
    drive(1'b1, 32'hFFFFFFFF, 32'd5,        1'b0, 4'b1101, 32'd0,        4'b0001, "nota");
    drive(1'b1, 32'h80000001, 32'd1,        1'b0, 4'b1111, 32'h40000000, 4'b1000, "lsr_carry");
    drive(1'b1, 32'h80000000, 32'h00000020, 1'b0, 4'b1111, 32'h80000000, 4'b0100, "lsr_zero_amt");
    drive(1'b1, 32'hF0000000, 32'd4,        1'b0, 4'b1110, 32'd0,        4'b1001, "lsl_out");
    drive(1'b0, 32'hFFFFFFFF, 32'd1,        1'b0, 4'b0000, 32'd0,        4'b0000, "reset_midstream");
    drive(1'b1, 32'd100,      32'd1,        1'b0, 4'b0010, 32'd99,       4'b1000, "sub_after_reset");

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations still pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
